dm_arbiter: RTL and testbench

- Two-port arbiter and access sequencer that shares the single 8 KB data memory (2048 x 32, word-addressed, byte-enabled, combinational read, write on posedge Clk) between the CPU load/store stage and the DMA engine.
- Arbitrates round-robin, runs one access per grant, generates byte enables from size and address, and returns aligned, extended read data over a 4-phase req/ack handshake.

---
 rtl/dm_arb_pkg.sv | 34 +++
 rtl/dm_arbiter_if.sv | 25 ++
 rtl/dm_lane_align.sv | 45 ++++
 rtl/dm_arbiter.sv | 111 +++++++++++
 tb/tb_dm_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Size, state, owner and byte-enable codes plus a size/alignment check.
package dm_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_HOLD   = 2'b10
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;

    // Invalid size code, odd halfword, or word not on a 4-byte boundary.
    function automatic logic size_bad(
        input logic [1:0] size,
        input logic [1:0] a
    );
        return (size == 2'b11)
            || ((size == SZ_HALF) && a[0])
            || ((size == SZ_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester port bundle: 4-phase req/ack access to the data memory.
// master = requester (CPU or DMA), slave = dm_arbiter.
interface dm_arbiter_if #(
    parameter int AW = 13
) ();
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic          sext;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic          ack;
    logic          err;
    logic [31:0]   rd;

    modport master (
        output req, we, size, sext, addr, wd,
        input  ack, err, rd
    );

    modport slave (
        input  req, we, size, sext, addr, wd,
        output ack, err, rd
    );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational lane logic: byte enables, misalignment flag, and the
// aligned, zero/sign-extended load result selected out of mem_RD.
// in: size, addr[1:0], sext, mem_RD  out: mem_BE, bad, rdata
module dm_lane_align
    import dm_arb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        sext,
    input  logic [31:0] mem_RD,
    output logic [3:0]  mem_BE,
    output logic        bad,
    output logic [31:0] rdata
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = mem_RD[{addr, 3'b000} +: 8];
        h      = mem_RD[{addr[1], 4'b0000} +: 16];
        bad    = size_bad(size, addr);
        mem_BE = 4'b0000;
        rdata  = '0;
        unique case (size)
            SZ_BYTE: begin
                mem_BE = 4'b0001 << addr;
                rdata  = {{24{sext & b[7]}}, b};
            end
            SZ_HALF: begin
                mem_BE = addr[1] ? BE_HHI : BE_HLO;
                rdata  = {{16{sext & h[15]}}, h};
            end
            SZ_WORD: begin
                mem_BE = BE_WORD;
                rdata  = mem_RD;
            end
            default: ;
        endcase
        // A rejected access returns zero data.
        if (bad)
            rdata = '0;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin CPU/DMA arbiter and sequencer for the 2048x32 data memory.
// Ports: Clk, Reset (sync, active-high); cpu/dma requester bundles
// (dm_arbiter_if.slave); mem_A/mem_BE/mem_WD/mem_We out, mem_RD in.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    dm_arbiter_if.slave   cpu,
    dm_arbiter_if.slave   dma,
    output logic [10:0]   mem_A,
    output logic [3:0]    mem_BE,
    output logic [DW-1:0] mem_WD,
    output logic          mem_We,
    input  logic [DW-1:0] mem_RD
);

    state_t        state;
    // owner also serves as the last grant for round-robin.
    owner_t        owner;
    logic          we_q;
    logic          sext_q;
    logic          err_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wd_q;
    logic [DW-1:0] rd_q;

    logic [3:0]    al_be;
    logic          al_bad;
    logic [DW-1:0] al_rd;

    logic          gnt_cpu;
    logic          own_req;
    logic          access;
    logic          cpu_own;
    logic          dma_own;

    dm_lane_align u_align (
        .size   (size_q),
        .addr   (addr_q[1:0]),
        .sext   (sext_q),
        .mem_RD (mem_RD),
        .mem_BE (al_be),
        .bad    (al_bad),
        .rdata  (al_rd)
    );

    // On a tie the port that did not win last time gets the grant.
    assign gnt_cpu = cpu.req & (~dma.req | (owner == OWN_DMA));
    assign own_req = (owner == OWN_CPU) ? cpu.req : dma.req;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_IDLE;
            owner  <= OWN_DMA;
            we_q   <= 1'b0;
            sext_q <= 1'b0;
            size_q <= SZ_BYTE;
            addr_q <= '0;
            wd_q   <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cpu.req | dma.req) begin
                        owner  <= gnt_cpu ? OWN_CPU : OWN_DMA;
                        we_q   <= gnt_cpu ? cpu.we   : dma.we;
                        size_q <= gnt_cpu ? cpu.size : dma.size;
                        sext_q <= gnt_cpu ? cpu.sext : dma.sext;
                        addr_q <= gnt_cpu ? cpu.addr : dma.addr;
                        wd_q   <= gnt_cpu ? cpu.wd   : dma.wd;
                        state  <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    rd_q  <= al_rd;
                    err_q <= al_bad;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!own_req)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign access  = (state == ST_ACCESS);
    assign cpu_own = (state == ST_HOLD) & (owner == OWN_CPU);
    assign dma_own = (state == ST_HOLD) & (owner == OWN_DMA);

    assign cpu.ack = cpu_own;
    assign cpu.err = cpu_own & err_q;
    assign cpu.rd  = cpu_own ? rd_q : '0;
    assign dma.ack = dma_own;
    assign dma.err = dma_own & err_q;
    assign dma.rd  = dma_own ? rd_q : '0;

    assign mem_A  = addr_q[AW-1:2];
    assign mem_WD = wd_q;
    assign mem_BE = access ? al_be : 4'b0000;
    // Reset gates the strobe directly so a reset in ACCESS never writes.
    assign mem_We = access & we_q & ~al_bad & ~Reset;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural 2048x32 memory.
// Directed CPU/DMA accesses, contention, reset-in-ACCESS and hold cases.
module tb_dm_arbiter;
    import dm_arb_pkg::*;

    typedef struct {
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    dm_arbiter_if #(.AW(13)) cpu_if ();
    dm_arbiter_if #(.AW(13)) dma_if ();

    logic [10:0] mem_A;
    logic [3:0]  mem_BE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;
    logic        mem_We;

    dm_arbiter #(.AW(13), .DW(32)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .cpu    (cpu_if),
        .dma    (dma_if),
        .mem_A  (mem_A),
        .mem_BE (mem_BE),
        .mem_WD (mem_WD),
        .mem_We (mem_We),
        .mem_RD (mem_RD)
    );

    // Memory: sub-word lanes take WD[7:0] / WD[15:0].
    logic [31:0] mem [0:2047];
    logic        mem_init = 1'b1;
    assign mem_RD = mem[mem_A];

    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 32'h0;
            mem[64] <= 32'h55AA55AA;
        end else if (mem_We) begin
            if (mem_BE == 4'b1111) mem[mem_A] <= mem_WD;
            else if (mem_BE == 4'b0011) mem[mem_A][15:0] <= mem_WD[15:0];
            else if (mem_BE == 4'b1100) mem[mem_A][31:16] <= mem_WD[15:0];
            else
                for (int b = 0; b < 4; b++)
                    if (mem_BE[b]) mem[mem_A][8*b +: 8] <= mem_WD[7:0];
        end
    end

    int   checks = 0;
    int   errors = 0;
    int   wr_cycles = 0;
    int   grant_log[$];
    exp_t exp_cpu[$];
    exp_t exp_dma[$];

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    task automatic score(int p, logic err, logic [31:0] rd);
        exp_t e;
        checks++;
        if ((p == 0 && exp_cpu.size() == 0) || (p == 1 && exp_dma.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_ack port %0d rd %h", p, rd);
            return;
        end
        if (p == 0) e = exp_cpu.pop_front();
        else        e = exp_dma.pop_front();
        if (err !== e.err || rd !== e.rd) begin
            errors++;
            $display("FAIL resp port %0d got err %b rd %h want err %b rd %h",
                     p, err, rd, e.err, e.rd);
        end
    endtask

    // Monitor: compares each response, checks exclusivity and rd stability.
    logic        cpu_prev = 1'b0;
    logic        dma_prev = 1'b0;
    logic [31:0] cpu_hrd  = '0;
    logic [31:0] dma_hrd  = '0;

    always @(negedge Clk) begin
        if (mem_We) wr_cycles++;
        if (cpu_if.ack || dma_if.ack) begin
            checks++;
            if (cpu_if.ack && dma_if.ack) begin
                errors++;
                $display("FAIL both_ack got 1 1 want one");
            end
        end
        if (cpu_if.ack && !cpu_prev) begin
            grant_log.push_back(0);
            cpu_hrd = cpu_if.rd;
            score(0, cpu_if.err, cpu_if.rd);
        end else if (cpu_if.ack) begin
            chk("cpu_rd_stable", cpu_if.rd, cpu_hrd);
        end
        if (dma_if.ack && !dma_prev) begin
            grant_log.push_back(1);
            dma_hrd = dma_if.rd;
            score(1, dma_if.err, dma_if.rd);
        end else if (dma_if.ack) begin
            chk("dma_rd_stable", dma_if.rd, dma_hrd);
        end
        cpu_prev = cpu_if.ack;
        dma_prev = dma_if.ack;
    end

    task automatic drive(int p, logic r, logic w, logic [1:0] sz, logic sx,
                         logic [12:0] a, logic [31:0] d);
        if (p == 0) begin
            cpu_if.we = w; cpu_if.size = sz; cpu_if.sext = sx;
            cpu_if.addr = a; cpu_if.wd = d; cpu_if.req = r;
        end else begin
            dma_if.we = w; dma_if.size = sz; dma_if.sext = sx;
            dma_if.addr = a; dma_if.wd = d; dma_if.req = r;
        end
    endtask

    task automatic set_req(int p, logic r);
        if (p == 0) cpu_if.req = r;
        else        dma_if.req = r;
    endtask

    function automatic logic ack_of(int p);
        return (p == 0) ? cpu_if.ack : dma_if.ack;
    endfunction

    // One full 4-phase access; called #1 after a rising edge.
    task automatic access(int p, logic w, logic [1:0] sz, logic sx,
                          logic [12:0] a, logic [31:0] d,
                          logic xerr, logic [31:0] xrd,
                          bit solo, int xbe, int hold);
        exp_t        e;
        int          n;
        int          w0;
        logic [3:0]  be_s;
        logic        we_s;
        logic [31:0] wd_s;
        e.err = xerr;
        e.rd  = xrd;
        if (p == 0) exp_cpu.push_back(e);
        else        exp_dma.push_back(e);
        w0 = wr_cycles; n = 0; be_s = '0; we_s = 1'b0; wd_s = '0;
        drive(p, 1'b1, w, sz, sx, a, d);
        while (!ack_of(p) && n < 40) begin
            @(posedge Clk); #1;
            n++;
            if (n == 1) begin
                be_s = mem_BE; we_s = mem_We; wd_s = mem_WD;
            end
        end
        if (!ack_of(p)) begin
            checks++; errors++;
            $display("FAIL ack_timeout port %0d got 0 want 1", p);
            set_req(p, 1'b0);
            return;
        end
        if (solo) begin
            chk("latency", n, 2);
            chk("access_we", {31'b0, we_s}, {31'b0, w & ~xerr});
            chk("write_cycles", wr_cycles - w0, {31'b0, w & ~xerr});
            if (xbe >= 0) chk("access_be", {28'b0, be_s}, xbe);
            if (w && !xerr) chk("access_wd", wd_s, d);
        end
        repeat (hold) begin
            @(posedge Clk); #1;
            chk("ack_held", {31'b0, ack_of(p)}, 1);
        end
        set_req(p, 1'b0);
        @(posedge Clk); #1;
        chk("ack_release", {31'b0, ack_of(p)}, 0);
    endtask

    int w0;

    initial begin
        drive(0, 1'b0, 1'b0, SZ_WORD, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, SZ_WORD, 1'b0, '0, '0);
        repeat (3) @(posedge Clk);
        #1;
        mem_init = 1'b0;
        Reset    = 1'b0;

        chk("rst_cpu_ack", {31'b0, cpu_if.ack}, 0);
        chk("rst_dma_ack", {31'b0, dma_if.ack}, 0);
        chk("rst_cpu_err", {31'b0, cpu_if.err}, 0);
        chk("rst_dma_err", {31'b0, dma_if.err}, 0);
        chk("rst_cpu_rd", cpu_if.rd, 0);
        chk("rst_dma_rd", dma_if.rd, 0);
        chk("rst_we", {31'b0, mem_We}, 0);
        chk("rst_be", {28'b0, mem_BE}, 0);

        access(0, 1, SZ_WORD, 0, 13'h040, 32'h11223344, 0, 32'h0,        1, 15, 0);
        access(0, 0, SZ_WORD, 0, 13'h040, 32'h0,        0, 32'h11223344, 1, 15, 0);
        access(0, 1, SZ_BYTE, 0, 13'h042, 32'h000000AB, 0, 32'h00000022, 1, 4,  0);
        access(0, 0, SZ_BYTE, 1, 13'h042, 32'h0,        0, 32'hFFFFFFAB, 1, 4,  0);
        access(0, 0, SZ_BYTE, 0, 13'h042, 32'h0,        0, 32'h000000AB, 1, 4,  0);
        access(0, 0, SZ_WORD, 0, 13'h040, 32'h0,        0, 32'h11AB3344, 1, 15, 0);
        access(0, 1, SZ_HALF, 0, 13'h046, 32'h00008001, 0, 32'h0,        1, 12, 0);
        access(0, 0, SZ_HALF, 1, 13'h046, 32'h0,        0, 32'hFFFF8001, 1, 12, 0);
        access(0, 1, SZ_HALF, 0, 13'h045, 32'h00001234, 1, 32'h0,        1, 3,  0);
        chk("mem_after_bad", mem[17], 32'h80010000);
        access(0, 0, SZ_WORD, 0, 13'h044, 32'h0,        0, 32'h80010000, 1, 15, 0);
        access(0, 0, 2'b11,   0, 13'h040, 32'h0,        1, 32'h0,        1, -1, 0);
        access(1, 0, SZ_WORD, 0, 13'h040, 32'h0,        0, 32'h11AB3344, 1, 15, 5);
        access(1, 0, SZ_WORD, 0, 13'h042, 32'h0,        1, 32'h0,        1, 15, 0);
        access(1, 0, SZ_BYTE, 1, 13'h041, 32'h0,        0, 32'h00000033, 1, 2,  0);

        // Reset arrives during the ACCESS cycle of a word store.
        drive(0, 1'b1, 1'b1, SZ_WORD, 1'b0, 13'h100, 32'hDEADBEEF);
        @(posedge Clk); #1;
        chk("pre_rst_we", {31'b0, mem_We}, 1);
        Reset = 1'b1;
        #1;
        chk("rst_gate_we", {31'b0, mem_We}, 0);
        w0 = wr_cycles;
        @(posedge Clk); #1;
        Reset = 1'b0;
        set_req(0, 1'b0);
        chk("rst_idle_cpu_ack", {31'b0, cpu_if.ack}, 0);
        chk("rst_idle_dma_ack", {31'b0, dma_if.ack}, 0);
        chk("rst_idle_be", {28'b0, mem_BE}, 0);
        @(posedge Clk); #1;
        chk("rst_no_write", mem[64], 32'h55AA55AA);
        chk("rst_wr_cycles", wr_cycles - w0, 0);

        // Contention straight out of reset: CPU, DMA, CPU, DMA.
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        grant_log.delete();
        fork
            begin
                access(0, 1, SZ_WORD, 0, 13'h080, 32'hA5A5A5A5, 0, 32'h0,        0, -1, 0);
                access(0, 0, SZ_WORD, 0, 13'h084, 32'h0,        0, 32'h5A5A5A5A, 0, -1, 0);
            end
            begin
                access(1, 1, SZ_WORD, 0, 13'h084, 32'h5A5A5A5A, 0, 32'h0,        0, -1, 0);
                access(1, 0, SZ_WORD, 0, 13'h080, 32'h0,        0, 32'hA5A5A5A5, 0, -1, 0);
            end
        join
        chk("grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("grant0", grant_log[0], 0);
            chk("grant1", grant_log[1], 1);
            chk("grant2", grant_log[2], 0);
            chk("grant3", grant_log[3], 1);
        end

        access(0, 0, SZ_WORD, 0, 13'h100, 32'h0, 0, 32'h55AA55AA, 1, 15, 0);

        chk("cpu_queue_empty", exp_cpu.size(), 0);
        chk("dma_queue_empty", exp_dma.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
